reaction_round_ctrl: RTL and testbench
======================================

# reaction_round_ctrl

Round controller for the multi-player reaction game. It sequences each round through a random countdown, a "go" window and a result hold. It arbitrates the players' debounced single-cycle press pulses from the one-pulse-per-press stages to pick exactly one winner, and keeps per-player scores. It sits between the per-button one-pulse stages and the display/lamp drivers.

## Interface
Parameters:
- NPLAYERS, 4: number of players, 2..8.
- SCORE_W, 4: width of each score counter.
- DELAY_W, 8: width of the random part of the countdown.
- MIN_DELAY, 64: fixed minimum countdown, in cycles.
- TIMEOUT, 1023: maximum length of the go window, in cycles.
- HOLD_CYCLES, 255: number of cycles the result is held.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a round; honoured only in IDLE.
- press  in  NPLAYERS  one-cycle press pulses, one bit per player.
- busy  out  1  high in every state except IDLE.
- go  out  1  go lamp; high only in ARMED.
- winner_valid  out  1  high during RESULT when a winner exists.
- winner_id  out  3  index of the winner; holds the last winner otherwise.
- round_done  out  1  one-cycle pulse on the RESULT→IDLE transition.
- foul  out  NPLAYERS  false-start flags for the current round.
- scores  out  NPLAYERS*SCORE_W  packed scores; player i occupies bits [i*SCORE_W +: SCORE_W].

## Operation
- States:
  - IDLE: start → WAIT.
  - WAIT: cnt == 0 → ARMED.
  - ARMED: a valid press → RESULT with a winner; cnt == 0 (timeout) → RESULT with no winner.
  - RESULT: cnt == 0 → IDLE.
- LFSR: 16-bit, x^16+x^14+x^13+x^11+1. Seeded 16'hACE1 at reset and advances every cycle in all states.
- Entering WAIT: cnt ← MIN_DELAY + lfsr[DELAY_W-1:0], and foul is cleared.
- Entering ARMED: cnt ← TIMEOUT.
- Entering RESULT: cnt ← HOLD_CYCLES.
- cnt decrements once per cycle in WAIT, ARMED and RESULT.
- Eligible press in ARMED: press[i] & ~foul[i]. Presses in IDLE and RESULT are ignored.
- Arbitration: round-robin among eligible presses in the same cycle.
  - Search starts at ptr and wraps at NPLAYERS.
  - ptr ← (winner + 1) mod NPLAYERS after each win; ptr = 0 at reset.
- Score: the winner's score increments and saturates at 2^SCORE_W − 1; other players' scores are unchanged.
- If every player is fouled while in WAIT, the round still proceeds to ARMED and times out.
- start in any state other than IDLE is ignored.

## Timing
- Reset values:
  - Outputs: busy=0, go=0, winner_valid=0, winner_id=0, round_done=0, foul=0, scores=0.
  - Internal: state IDLE, cnt=0, ptr=0.
- Reset mid-round aborts immediately to IDLE and clears scores.
- start sampled in cycle t → busy=1 from t+1.
- WAIT lasts MIN_DELAY + lfsr_value + 1 cycles.
- go rises on the first ARMED cycle.
- A press sampled in ARMED cycle t gives, at t+1: go=0, winner_valid=1, winner_id and score updated.
- The press cycle that coincides with the timeout cycle counts as a win.
- A timeout with no press gives RESULT with winner_valid=0 and no score change.
- RESULT lasts HOLD_CYCLES + 1 cycles.
- round_done is high in the first IDLE cycle, and winner_valid drops in that same cycle.
- All outputs are registered; there is no combinational path from press to any output.

## Configuration
- FALSE_START_EN defined:
  - press[i] during WAIT sets foul[i].
  - A fouled player is ineligible in ARMED for the rest of that round.
  - The fouled player's score decrements, saturating at 0.
- FALSE_START_EN undefined:
  - Presses in WAIT are ignored.
  - foul is tied to 0.
  - No decrement logic is built.

## Test plan
- Reset then single press: NPLAYERS=4, start, press=4'b0100 on the first go cycle → next cycle winner_valid=1, winner_id=2, scores[2]=1, go=0.
- Simultaneous tie and rotation:
  - ptr=0, press=4'b1010 → winner 1, ptr becomes 2.
  - Next round, press=4'b1010 → winner 3.
- Timeout: no presses for TIMEOUT+1 ARMED cycles → RESULT with winner_valid=0, scores unchanged, and round_done exactly HOLD_CYCLES+1 cycles later.
- Saturation: with SCORE_W=4, 16 wins by player 0 → scores[0] stays 15.
- False start (FALSE_START_EN defined):
  - Player 1 presses in WAIT → foul=4'b0010 and scores[1] decremented, floored at 0.
  - Player 1 presses in ARMED → ignored; player 3's later press wins.
- Async reset mid-ARMED: rst asserted → go=0, busy=0, scores=0 without waiting for a clock edge; start ignored while in RESULT.

Source files
------------

// File: rtl/reaction_round_ctrl.sv
// Round controller for the reaction game: random countdown, go window, result hold,
// round-robin winner arbitration and saturating scores. Optional false-start handling: FALSE_START_EN.
module reaction_round_ctrl #(
    parameter int NPLAYERS    = 4,
    parameter int SCORE_W     = 4,
    parameter int DELAY_W     = 8,
    parameter int MIN_DELAY   = 64,
    parameter int TIMEOUT     = 1023,
    parameter int HOLD_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NPLAYERS-1:0]           press,
    output logic                          busy,
    output logic                          go,
    output logic                          winner_valid,
    output logic [2:0]                    winner_id,
    output logic                          round_done,
    output logic [NPLAYERS-1:0]           foul,
    output logic [NPLAYERS*SCORE_W-1:0]   scores
);

    localparam int WAIT_MAX = MIN_DELAY + (1 << DELAY_W) - 1;
    localparam int AH_MAX   = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int CNT_MAX  = (WAIT_MAX > AH_MAX) ? WAIT_MAX : AH_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ARMED,
        ST_RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [NPLAYERS-1:0]  foul_q, foul_d;
    logic                 win_valid_q, win_valid_d;
    logic [2:0]           win_id_q, win_id_d;
    logic                 round_done_q, round_done_d;
    logic [SCORE_W-1:0]   score_q [NPLAYERS];
    logic [SCORE_W-1:0]   score_d [NPLAYERS];

    logic [7:0]           elig8;
    logic [3:0]           rr_sum;
    logic [2:0]           rr_idx;
    logic                 win_found;
    logic [2:0]           win_idx;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

`ifdef FALSE_START_EN
    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction
`endif

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Round-robin pick: first eligible player at or after ptr, wrapping at NPLAYERS
    always_comb begin
        elig8     = 8'(press & ~foul_q);
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NPLAYERS; k++) begin
            rr_sum = {1'b0, ptr_q} + 4'(k);
            if (rr_sum >= 4'(NPLAYERS)) begin
                rr_sum = rr_sum - 4'(NPLAYERS);
            end
            rr_idx = rr_sum[2:0];
            if (!win_found && elig8[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        foul_d       = foul_q;
        win_valid_d  = win_valid_q;
        win_id_d     = win_id_q;
        round_done_d = 1'b0;
        score_d      = score_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_q[DELAY_W-1:0]);
                    foul_d  = '0;
                end
            end
            ST_WAIT: begin
`ifdef FALSE_START_EN
                // Only the first false start of a round costs a point
                for (int i = 0; i < NPLAYERS; i++) begin
                    if (press[i] && !foul_q[i]) begin
                        foul_d[i]  = 1'b1;
                        score_d[i] = sat_dec(score_q[i]);
                    end
                end
`endif
                if (cnt_q == '0) begin
                    state_d = ST_ARMED;
                    cnt_d   = CNT_W'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ARMED: begin
                // A press on the final timeout cycle still wins
                if (win_found) begin
                    state_d     = ST_RESULT;
                    cnt_d       = CNT_W'(HOLD_CYCLES);
                    win_valid_d = 1'b1;
                    win_id_d    = win_idx;
                    ptr_d       = (win_idx == 3'(NPLAYERS - 1)) ? 3'd0 : win_idx + 3'd1;
                    for (int i = 0; i < NPLAYERS; i++) begin
                        if (win_idx == 3'(i)) begin
                            score_d[i] = sat_inc(score_q[i]);
                        end
                    end
                end else if (cnt_q == '0) begin
                    state_d     = ST_RESULT;
                    cnt_d       = CNT_W'(HOLD_CYCLES);
                    win_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESULT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_IDLE;
                    win_valid_d  = 1'b0;
                    round_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            lfsr_q       <= 16'hACE1;
            foul_q       <= '0;
            win_valid_q  <= 1'b0;
            win_id_q     <= '0;
            round_done_q <= 1'b0;
            for (int i = 0; i < NPLAYERS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            lfsr_q       <= lfsr_d;
            foul_q       <= foul_d;
            win_valid_q  <= win_valid_d;
            win_id_q     <= win_id_d;
            round_done_q <= round_done_d;
            score_q      <= score_d;
        end
    end

    always_comb begin
        scores = '0;
        for (int i = 0; i < NPLAYERS; i++) begin
            scores[i*SCORE_W +: SCORE_W] = score_q[i];
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign go           = (state_q == ST_ARMED);
    assign winner_valid = win_valid_q;
    assign winner_id    = win_id_q;
    assign round_done   = round_done_q;
    assign foul         = foul_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Randomized self-checking bench for reaction_round_ctrl against a round-level reference model.
module tb_reaction_round_ctrl;

    localparam int NP      = 4;
    localparam int SW      = 4;
    localparam int DW      = 3;
    localparam int MIND    = 4;
    localparam int TOUT    = 20;
    localparam int HOLD    = 5;
    localparam int BOUND   = 300;

    logic              clk;
    logic              rst;
    logic              start;
    logic [NP-1:0]     press;
    logic              busy;
    logic              go;
    logic              winner_valid;
    logic [2:0]        winner_id;
    logic              round_done;
    logic [NP-1:0]     foul;
    logic [NP*SW-1:0]  scores;

    int checks = 0;
    int errors = 0;

    logic [15:0]   m_lfsr;
    int            m_score [NP];
    int            m_ptr;
    int            m_last;
    logic [NP-1:0] m_foul;

    reaction_round_ctrl #(
        .NPLAYERS(NP), .SCORE_W(SW), .DELAY_W(DW),
        .MIN_DELAY(MIND), .TIMEOUT(TOUT), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .press(press),
        .busy(busy), .go(go), .winner_valid(winner_valid), .winner_id(winner_id),
        .round_done(round_done), .foul(foul), .scores(scores)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference random sequence, advanced on every clock after reset
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    function automatic int rr_pick(input logic [NP-1:0] e, input int p);
        for (int k = 0; k < NP; k++) begin
            int idx;
            idx = (p + k) % NP;
            if (((e >> idx) & NP'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NP*SW-1:0] pack_scores();
        logic [NP*SW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*SW +: SW] = SW'(m_score[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_ptr  = 0;
        m_last = 0;
        m_foul = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; press = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", go); end
        checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL reset_wv got %b want 0", winner_valid); end
        checks++; if (winner_id !== 3'd0) begin errors++; $display("FAIL reset_wid got %0d want 0", winner_id); end
        checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", round_done); end
        checks++; if (foul !== '0) begin errors++; $display("FAIL reset_foul got %b want 0", foul); end
        checks++; if (scores !== '0) begin errors++; $display("FAIL reset_scores got %h want 0", scores); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // From an IDLE negedge: start a round, optionally press during the first WAIT cycle,
    // and stop at the first ARMED negedge.
    task automatic do_start(input logic [NP-1:0] wp);
        int n;
        int exp_wait;
        exp_wait = MIND + int'(m_lfsr[DW-1:0]) + 1;
        m_foul = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || go !== 1'b0) begin errors++; $display("FAIL start_busy got busy=%b go=%b want 1/0", busy, go); end
        press = wp;
`ifdef FALSE_START_EN
        for (int i = 0; i < NP; i++) begin
            if (wp[i] && !m_foul[i]) begin
                m_foul[i] = 1'b1;
                if (m_score[i] > 0) m_score[i]--;
            end
        end
`endif
        n = 0;
        while (go !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            press = '0;
            n++;
        end
        checks++; if (n != exp_wait) begin errors++; $display("FAIL wait_len got %0d want %0d", n, exp_wait); end
        checks++; if (foul !== m_foul) begin errors++; $display("FAIL foul got %b want %b", foul, m_foul); end
        checks++; if (scores !== pack_scores()) begin errors++; $display("FAIL wait_scores got %h want %h", scores, pack_scores()); end
    endtask

    // From the first ARMED negedge: press p1 at ARMED cycle d1 and p2 at d2 (d2 > d1),
    // then run the result hold with start and random presses that must be ignored.
    task automatic run_armed(input logic [NP-1:0] p1, input int d1, input logic [NP-1:0] p2, input int d2);
        int a;
        int n;
        int w;
        int exp_a;
        logic [NP*SW-1:0] held;
        w = rr_pick(p1 & ~m_foul, m_ptr);
        if (w >= 0) exp_a = d1 + 1;
        else begin
            w = rr_pick(p2 & ~m_foul, m_ptr);
            exp_a = (w >= 0) ? d2 + 1 : TOUT + 1;
        end
        a = 0;
        while (go === 1'b1 && a < BOUND) begin
            press = (a == d1) ? p1 : (a == d2) ? p2 : '0;
            @(negedge clk);
            a++;
        end
        press = '0;
        if (w >= 0) begin
            if (m_score[w] < (1 << SW) - 1) m_score[w]++;
            m_ptr  = (w + 1) % NP;
            m_last = w;
        end
        checks++; if (a != exp_a) begin errors++; $display("FAIL armed_len got %0d want %0d", a, exp_a); end
        checks++; if (winner_valid !== (w >= 0)) begin errors++; $display("FAIL winner_valid got %b want %b", winner_valid, (w >= 0)); end
        checks++; if (winner_id !== 3'(m_last)) begin errors++; $display("FAIL winner_id got %0d want %0d", winner_id, m_last); end
        checks++; if (scores !== pack_scores()) begin errors++; $display("FAIL result_scores got %h want %h", scores, pack_scores()); end
        checks++; if (go !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL result_lamps got go=%b busy=%b want 0/1", go, busy); end
        held = pack_scores();
        n = 0;
        while (round_done !== 1'b1 && n < BOUND) begin
            start = 1'b1;
            press = NP'($urandom_range(0, (1 << NP) - 1));
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        press = '0;
        checks++; if (n != HOLD + 1) begin errors++; $display("FAIL hold_len got %0d want %0d", n, HOLD + 1); end
        checks++; if (winner_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_flags got wv=%b busy=%b want 0/0", winner_valid, busy); end
        checks++; if (scores !== held) begin errors++; $display("FAIL hold_scores got %h want %h", scores, held); end
        @(negedge clk);
        checks++; if (round_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_done got rd=%b busy=%b want 0/0", round_done, busy); end
    endtask

    task automatic test_single_press();
        do_start('0);
        run_armed(4'b0100, 0, '0, TOUT + 5);
    endtask

    task automatic test_tie_rotation();
        test_reset();
        do_start('0);
        run_armed(4'b1010, 0, '0, TOUT + 5);
        do_start('0);
        run_armed(4'b1010, 2, '0, TOUT + 5);
    endtask

    task automatic test_timeout();
        do_start('0);
        run_armed('0, TOUT + 5, '0, TOUT + 6);
    endtask

    task automatic test_last_cycle_press();
        do_start('0);
        run_armed(4'b0001, TOUT, '0, TOUT + 5);
    endtask

    task automatic test_false_start();
        do_start(4'b0010);
        run_armed(4'b0010, 0, 4'b1000, 3);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 17; r++) begin
            do_start('0);
            run_armed(4'b0001, $urandom_range(0, 3), '0, TOUT + 5);
        end
        checks++; if (scores[SW-1:0] !== 4'd15) begin errors++; $display("FAIL saturation got %0d want 15", scores[SW-1:0]); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            int d1;
            d1 = $urandom_range(0, TOUT);
            do_start(($urandom_range(0, 3) == 0) ? NP'($urandom_range(0, (1 << NP) - 1)) : '0);
            run_armed(NP'($urandom_range(0, (1 << NP) - 1)), d1,
                      NP'($urandom_range(0, (1 << NP) - 1)), d1 + 1 + $urandom_range(0, 4));
        end
    endtask

    task automatic test_async_reset();
        do_start('0);
        #1 rst = 1'b1;
        #1;
        checks++; if (go !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_lamps got go=%b busy=%b want 0/0", go, busy); end
        checks++; if (scores !== '0) begin errors++; $display("FAIL async_rst_scores got %h want 0", scores); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start('0);
        run_armed(4'b0110, 1, '0, TOUT + 5);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_tie_rotation();
        test_timeout();
        test_last_cycle_press();
        test_false_start();
        test_false_start();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
